timer_reg_if: RTL
=================

TIMER_REG_IF -- requirements
Module: timer_reg_if

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset: pclk  input  1  APB/system clock; all logic on rising edge.
REQ-002 SHALL have: preset  input  1  synchronous active-high reset, sampled on pclk rising edge.
REQ-003 SHALL have APB slave inputs: psel 1; penable 1; pwrite 1; paddr 8 (byte address); pwdata 8.
REQ-004 SHALL have APB slave outputs: pready 1; prdata 8; pslverr 1.
REQ-005 SHALL have counter-side inputs: ovf_set 1 (one-pclk overflow pulse); udf_set 1 (one-pclk underflow pulse).
REQ-006 SHALL have counter-side outputs: tdr 8 (reload value); load 1; dw 1 (1 = count down); en 1; cks 2 (00 clk2, 01 clk4, 10 clk8, 11 clk16); tmr_int 1 (interrupt).

Function
REQ-007 SHALL map registers: 0x00 TDR RW[7:0]; 0x01 TCR RW bits 7 load, 5 dw, 4 en, 1:0 cks, reserved bits 6/3/2 read 0; 0x02 TSR bit1 UDF, bit0 OVF, W1C; 0x03 TIER bit1 UDF_IE, bit0 OVF_IE; other bits read 0.
REQ-008 SHALL implement FSM IDLE -> SETUP (psel & !penable) -> WAIT (psel & penable, pready=0) -> ACCESS (pready=1, one cycle) -> IDLE; exactly one wait state per transfer.
REQ-009 SHALL return SETUP -> IDLE and WAIT -> IDLE if psel deasserts, with no register update.
REQ-010 SHALL commit writes only on the pclk edge ending ACCESS (psel & penable & pwrite & pready).
REQ-011 SHALL drive prdata with the addressed register only during ACCESS of a read; 0x00 otherwise.
REQ-012 SHALL drive TCR fields continuously onto load, dw, en, cks; tdr mirrors TDR.
REQ-013 SHALL set TSR[0] on ovf_set and TSR[1] on udf_set, one cycle after the pulse.
REQ-014 SHALL clear TSR bit n on a TSR write with pwdata[n]=1; 0 bits leave state unchanged.
REQ-015 SHALL give hardware set priority over W1C clear in the same cycle (bit remains 1).
REQ-016 SHALL drive tmr_int = registered (TSR[0]&TIER[0]) | (TSR[1]&TIER[1]), one-cycle latency from TSR/TIER change.
REQ-017 SHALL ignore reserved-bit write data; TCR reads back pwdata & 0xB3.
REQ-018 SHALL drive pslverr low except as in Configuration.

Reset
REQ-019 SHALL, while preset=1, set TDR=TCR=TSR=TIER=0x00, FSM=IDLE, pready=0, prdata=0x00, pslverr=0, tmr_int=0.
REQ-020 SHALL abort any in-flight transfer on reset without committing a write; ovf_set/udf_set during reset are ignored.

Configuration
REQ-021 SHALL, with TIMER_REG_PSLVERR_EN defined, assert pslverr together with pready in ACCESS for any paddr > 0x03, blocking any register update; reads return 0x00.
REQ-022 SHALL, without TIMER_REG_PSLVERR_EN, tie pslverr to 0; out-of-range writes are silently dropped and reads return 0x00.

Verification
REQ-023 SHALL cover: write 0x00<=0xFF, then TCR<=0x83, then TCR<=0x33 -> tdr=0xFF, load=0, dw=1, en=1, cks=11; TCR read returns 0x33.
REQ-024 SHALL cover: udf_set pulse, then read 0x02 -> prdata=0x02; write 0x02<=0x02 -> subsequent read returns 0x00.
REQ-025 SHALL cover: TIER<=0x02, udf_set pulse -> tmr_int=1 two cycles after pulse; W1C of TSR -> tmr_int=0.
REQ-026 SHALL cover: ovf_set in the same cycle as write 0x02<=0x01 commits -> TSR reads 0x01.
REQ-027 SHALL cover: every transfer -> pready low in WAIT, high for exactly one cycle; preset asserted in WAIT of write TDR<=0x55 -> TDR stays 0x00.
REQ-028 SHALL cover: write 0x07<=0xAA -> pslverr=1 with pready and no register change with TIMER_REG_PSLVERR_EN; pslverr=0 and no register change without it.

Source files
------------

// File: rtl/timer_reg_if.sv
// APB-style register block for an 8-bit timer: TDR, TCR, TSR (W1C), TIER.
// Define TIMER_REG_PSLVERR_EN to flag accesses above 0x03 with pslverr.
module timer_reg_if (
   input  logic       pclk,
   input  logic       preset,
   input  logic       psel,
   input  logic       penable,
   input  logic       pwrite,
   input  logic [7:0] paddr,
   input  logic [7:0] pwdata,
   output logic       pready,
   output logic [7:0] prdata,
   output logic       pslverr,
   input  logic       ovf_set,
   input  logic       udf_set,
   output logic [7:0] tdr,
   output logic       load,
   output logic       dw,
   output logic       en,
   output logic [1:0] cks,
   output logic       tmr_int
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SETUP,
      S_WAIT,
      S_ACCESS
   } state_t;

   state_t     state_q, state_d;
   logic [7:0] tdr_q, tdr_d;
   logic [7:0] tcr_q, tcr_d;
   logic [1:0] tsr_q, tsr_d;
   logic [1:0] tier_q, tier_d;
   logic       int_q, int_d;

   logic       in_acc;
   logic       addr_ok;
   logic       wr_en;
   logic [1:0] tsr_clr;
   logic [7:0] rdata;

   assign in_acc  = (state_q == S_ACCESS) & psel & penable;
   assign addr_ok = (paddr[7:2] == 6'd0);
   assign wr_en   = in_acc & pwrite & addr_ok;

   // Transfer sequencing: one setup, one wait, one access cycle
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: begin
            if (psel & ~penable) state_d = S_SETUP;
         end
         S_SETUP: begin
            if (~psel)        state_d = S_IDLE;
            else if (penable) state_d = S_WAIT;
         end
         S_WAIT: begin
            if (~psel) state_d = S_IDLE;
            else       state_d = S_ACCESS;
         end
         S_ACCESS: begin
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Register read mux; unmapped bits read as zero
   always_comb begin
      rdata = 8'h00;
      unique case (paddr[1:0])
         2'd0: rdata = tdr_q;
         2'd1: rdata = tcr_q;
         2'd2: rdata = {6'd0, tsr_q};
         2'd3: rdata = {6'd0, tier_q};
         default: rdata = 8'h00;
      endcase
   end

   assign pready = (state_q == S_ACCESS);
   assign prdata = (in_acc & ~pwrite & addr_ok) ? rdata : 8'h00;

`ifdef TIMER_REG_PSLVERR_EN
   assign pslverr = in_acc & ~addr_ok;
`else
   assign pslverr = 1'b0;
`endif

   // Next register values; hardware set wins over W1C clear
   always_comb begin
      tdr_d   = tdr_q;
      tcr_d   = tcr_q;
      tier_d  = tier_q;
      tsr_clr = 2'b00;
      if (wr_en) begin
         unique case (paddr[1:0])
            2'd0: tdr_d   = pwdata;
            2'd1: tcr_d   = pwdata & 8'hB3;
            2'd2: tsr_clr = pwdata[1:0];
            2'd3: tier_d  = pwdata[1:0];
            default: ;
         endcase
      end
      tsr_d = (tsr_q & ~tsr_clr) | {udf_set, ovf_set};
      int_d = |(tsr_q & tier_q);
   end

   // State and register update with synchronous reset
   always_ff @(posedge pclk) begin
      if (preset) begin
         state_q <= S_IDLE;
         tdr_q   <= 8'h00;
         tcr_q   <= 8'h00;
         tsr_q   <= 2'b00;
         tier_q  <= 2'b00;
         int_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         tdr_q   <= tdr_d;
         tcr_q   <= tcr_d;
         tsr_q   <= tsr_d;
         tier_q  <= tier_d;
         int_q   <= int_d;
      end
   end

   assign tdr     = tdr_q;
   assign load    = tcr_q[7];
   assign dw      = tcr_q[5];
   assign en      = tcr_q[4];
   assign cks     = tcr_q[1:0];
   assign tmr_int = int_q;

endmodule
